// File: rtl/router_ingress_arbiter.sv
// Round-robin, packet-granular arbiter that shares the router ingress port
// between NSRC byte-stream sources and delimits packets by header length.
module router_ingress_arbiter #(
   parameter int unsigned NSRC       = 3,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [NSRC-1:0]     src_pkt_valid,
   input  logic [8*NSRC-1:0]   src_data,
   output logic [NSRC-1:0]     src_busy,
   input  logic                rtr_busy,
   output logic                rtr_pkt_valid,
   output logic [7:0]          rtr_data,
   output logic [NSRC-1:0]     grant,
   output logic                pkt_done,
   output logic                len_err
);

   localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned LW = 6;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_PLD  = 3'd2,
      S_PAR  = 3'd3,
      S_GAP  = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [NSRC-1:0] grant_q, grant_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [IW-1:0]   last_q, last_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   len_q, len_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic            pkt_done_q, pkt_done_d;
   logic            len_err_q, len_err_d;

   logic [7:0]      src_byte [NSRC];
   logic            sel_valid;
   logic [7:0]      sel_data;
   logic            pick_found;
   logic [IW-1:0]   pick_idx;

   // Split the flat source data bus into per-source bytes
   always_comb begin
      for (int unsigned i = 0; i < NSRC; i++) begin
         src_byte[i] = src_data[8*i +: 8];
      end
   end

   assign sel_valid = src_pkt_valid[gidx_q];
   assign sel_data  = src_byte[gidx_q];

   // Round-robin pick: first requester strictly after the last served source
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned k = 1; k <= NSRC; k++) begin
         int unsigned idx;
         idx = (32'(last_q) + k) % NSRC;
         if (!pick_found && src_pkt_valid[IW'(idx)]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(idx);
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         last_q     <= IW'(NSRC - 1);
         cnt_q      <= '0;
         len_q      <= '0;
         gap_q      <= '0;
         pkt_done_q <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         gap_q      <= gap_d;
         pkt_done_q <= pkt_done_d;
         len_err_q  <= len_err_d;
      end
   end

   // Next-state logic; rtr_busy freezes everything in the forwarding states
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      gap_d      = gap_q;
      pkt_done_d = 1'b0;
      len_err_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d = NSRC'(1) << pick_idx;
               gidx_d  = pick_idx;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            if (!sel_valid) begin
               // Source withdrew before its header was taken
               grant_d = '0;
               state_d = S_IDLE;
            end else if (!rtr_busy) begin
               len_d   = sel_data[7:2];
               cnt_d   = '0;
               state_d = (sel_data[7:2] == '0) ? S_PAR : S_PLD;
            end
         end
         S_PLD: begin
            if (!rtr_busy) begin
               if (sel_valid) begin
                  cnt_d = cnt_q + LW'(1);
                  if (cnt_q + LW'(1) == len_q) begin
                     state_d = S_PAR;
                  end
               end else begin
                  // Short packet: this byte went out as parity
                  len_err_d = 1'b1;
                  grant_d   = '0;
                  last_d    = gidx_q;
                  gap_d     = '0;
                  state_d   = S_GAP;
               end
            end
         end
         S_PAR: begin
            if (!rtr_busy) begin
               pkt_done_d = 1'b1;
               len_err_d  = sel_valid;
               grant_d    = '0;
               last_d     = gidx_q;
               gap_d      = '0;
               state_d    = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Router-side and source-side port drive, combinational on the current state
   always_comb begin
      rtr_pkt_valid = 1'b0;
      rtr_data      = '0;
      src_busy      = '1;
      case (state_q)
         S_HDR, S_PLD: begin
            rtr_pkt_valid    = sel_valid;
            rtr_data         = sel_data;
            src_busy[gidx_q] = rtr_busy;
         end
         S_PAR: begin
            rtr_data         = sel_data;
            src_busy[gidx_q] = rtr_busy;
         end
         default: begin
            rtr_pkt_valid = 1'b0;
         end
      endcase
   end

   assign grant    = grant_q;
   assign pkt_done = pkt_done_q;
   assign len_err  = len_err_q;

endmodule

// File: tb/tb_router_ingress_arbiter.sv
// Directed bench for router_ingress_arbiter: queued byte sources, router-side transfer log.
module tb_router_ingress_arbiter;

   localparam int unsigned NSRC = 3;
   localparam int unsigned GAP  = 2;

   logic                clock = 1'b0;
   logic                resetn;
   logic [NSRC-1:0]     src_pkt_valid;
   logic [8*NSRC-1:0]   src_data;
   logic [NSRC-1:0]     src_busy;
   logic                rtr_busy;
   logic                rtr_pkt_valid;
   logic [7:0]          rtr_data;
   logic [NSRC-1:0]     grant;
   logic                pkt_done;
   logic                len_err;

   always #5 clock = ~clock;

   router_ingress_arbiter #(.NSRC(NSRC), .GAP_CYCLES(GAP)) dut (
      .clock         (clock),
      .resetn        (resetn),
      .src_pkt_valid (src_pkt_valid),
      .src_data      (src_data),
      .src_busy      (src_busy),
      .rtr_busy      (rtr_busy),
      .rtr_pkt_valid (rtr_pkt_valid),
      .rtr_data      (rtr_data),
      .grant         (grant),
      .pkt_done      (pkt_done),
      .len_err       (len_err)
   );

   typedef struct packed {
      logic       vld;
      logic [7:0] dat;
   } ent_t;

   typedef struct {
      int         cyc;
      logic [7:0] dat;
      logic       vld;
   } xf_t;

   ent_t srcq [NSRC][$];
   xf_t  xlog[$];
   int   pd_log[$];
   int   le_log[$];
   int   cyc    = 0;
   int   errs   = 0;
   int   checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_sources();
      for (int i = 0; i < int'(NSRC); i++) begin
         if (srcq[i].size() > 0) begin
            src_pkt_valid[i]   = srcq[i][0].vld;
            src_data[8*i +: 8] = srcq[i][0].dat;
         end else begin
            src_pkt_valid[i]   = 1'b0;
            src_data[8*i +: 8] = 8'h00;
         end
      end
   endtask

   task automatic push(input int s, input logic v, input logic [7:0] d);
      ent_t e;
      e.vld = v;
      e.dat = d;
      srcq[s].push_back(e);
   endtask

   task automatic clear_logs();
      xlog.delete();
      pd_log.delete();
      le_log.delete();
   endtask

   // One clock: sample the port before the edge, then consume and log after it
   task automatic tick();
      logic [NSRC-1:0] busy_s;
      logic [NSRC-1:0] g_s;
      logic [7:0]      d_s;
      logic            v_s;
      xf_t             e;
      @(negedge clock);
      busy_s = src_busy;
      g_s    = grant;
      d_s    = rtr_data;
      v_s    = rtr_pkt_valid;
      @(posedge clock);
      #1;
      cyc++;
      if (|(g_s & ~busy_s)) begin
         e.cyc = cyc;
         e.dat = d_s;
         e.vld = v_s;
         xlog.push_back(e);
      end
      for (int i = 0; i < int'(NSRC); i++) begin
         if (!busy_s[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      end
      if (pkt_done === 1'b1) pd_log.push_back(cyc);
      if (len_err === 1'b1) le_log.push_back(cyc);
      drive_sources();
   endtask

   task automatic do_reset();
      resetn   = 1'b0;
      rtr_busy = 1'b0;
      for (int i = 0; i < int'(NSRC); i++) srcq[i].delete();
      drive_sources();
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      clear_logs();
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      int left;
      n    = 0;
      left = srcq[0].size() + srcq[1].size() + srcq[2].size();
      while (left != 0 && n < budget) begin
         tick();
         n++;
         left = srcq[0].size() + srcq[1].size() + srcq[2].size();
      end
      check_eq({tag, "_drain"}, 32'(left), 32'd0);
      repeat (GAP + 2) tick();
   endtask

   task automatic wait_xf(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (xlog.size() < n && k < budget) begin
         tick();
         k++;
      end
      check_eq({tag, "_reach"}, 32'(xlog.size() >= n), 32'd1);
   endtask

   task automatic check_xf(input string tag, input int k, input logic [7:0] d, input logic v);
      if (k < xlog.size()) begin
         check_eq({tag, "_data"}, 32'(xlog[k].dat), 32'(d));
         check_eq({tag, "_vld"}, 32'(xlog[k].vld), 32'(v));
      end else begin
         check_eq({tag, "_missing"}, 32'(xlog.size()), 32'(k + 1));
      end
   endtask

   task automatic check_cyc_gap(input string tag, input int a, input int b, input int d);
      if (b < xlog.size()) check_eq(tag, 32'(xlog[b].cyc - xlog[a].cyc), 32'(d));
      else check_eq({tag, "_missing"}, 32'(xlog.size()), 32'(b + 1));
   endtask

   logic [7:0] t2d [9] = '{8'h04, 8'h11, 8'h15, 8'h05, 8'h22, 8'h27, 8'h06, 8'h33, 8'h35};
   logic [7:0] t3d [6] = '{8'h11, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h5A};

   initial begin
      int c0;
      resetn        = 1'b0;
      rtr_busy      = 1'b0;
      src_pkt_valid = '0;
      src_data      = '0;
      drive_sources();

      // Test 1: single source, len 2
      do_reset();
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_src_busy", 32'(src_busy), 32'h7);
      check_eq("rst_rtr_valid", 32'(rtr_pkt_valid), 32'd0);
      check_eq("rst_rtr_data", 32'(rtr_data), 32'd0);
      check_eq("rst_pkt_done", 32'(pkt_done), 32'd0);
      check_eq("rst_len_err", 32'(len_err), 32'd0);
      c0 = cyc;
      push(0, 1'b1, 8'h09);
      push(0, 1'b1, 8'hA5);
      push(0, 1'b1, 8'h3C);
      push(0, 1'b0, 8'h90);
      drive_sources();
      tick();
      check_eq("t1_grant", 32'(grant), 32'h1);
      repeat (4) tick();
      check_eq("t1_gap0_grant", 32'(grant), 32'd0);
      check_eq("t1_gap0_busy", 32'(src_busy), 32'h7);
      check_eq("t1_gap0_done", 32'(pkt_done), 32'd1);
      check_eq("t1_gap0_rvld", 32'(rtr_pkt_valid), 32'd0);
      check_eq("t1_gap0_rdata", 32'(rtr_data), 32'd0);
      tick();
      check_eq("t1_gap1_busy", 32'(src_busy), 32'h7);
      check_eq("t1_gap1_done", 32'(pkt_done), 32'd0);
      repeat (3) tick();
      check_eq("t1_nxf", 32'(xlog.size()), 32'd4);
      check_xf("t1_x0", 0, 8'h09, 1'b1);
      check_xf("t1_x1", 1, 8'hA5, 1'b1);
      check_xf("t1_x2", 2, 8'h3C, 1'b1);
      check_xf("t1_x3", 3, 8'h90, 1'b0);
      if (xlog.size() > 0) check_eq("t1_first_cyc", 32'(xlog[0].cyc), 32'(c0 + 2));
      else check_eq("t1_first_missing", 32'd0, 32'd1);
      check_cyc_gap("t1_back2back", 0, 3, 3);
      check_eq("t1_npd", 32'(pd_log.size()), 32'd1);
      if (pd_log.size() > 0) check_eq("t1_pd_cyc", 32'(pd_log[0]), 32'(c0 + 5));
      check_eq("t1_nle", 32'(le_log.size()), 32'd0);

      // Test 2: three simultaneous requesters, then 0 and 2 again
      do_reset();
      push(0, 1'b1, 8'h04); push(0, 1'b1, 8'h11); push(0, 1'b0, 8'h15);
      push(1, 1'b1, 8'h05); push(1, 1'b1, 8'h22); push(1, 1'b0, 8'h27);
      push(2, 1'b1, 8'h06); push(2, 1'b1, 8'h33); push(2, 1'b0, 8'h35);
      drive_sources();
      tick();
      check_eq("t2_grant0", 32'(grant), 32'h1);
      wait_drain("t2a", 80);
      check_eq("t2_nxf", 32'(xlog.size()), 32'd9);
      for (int k = 0; k < 9; k++) check_xf($sformatf("t2_x%0d", k), k, t2d[k], (k % 3) != 2);
      check_cyc_gap("t2_gap_spacing", 2, 3, 4);
      check_eq("t2_npd", 32'(pd_log.size()), 32'd3);
      clear_logs();
      push(0, 1'b1, 8'h04); push(0, 1'b1, 8'h44); push(0, 1'b0, 8'h40);
      push(2, 1'b1, 8'h06); push(2, 1'b1, 8'h66); push(2, 1'b0, 8'h60);
      drive_sources();
      tick();
      check_eq("t2_rr_grant", 32'(grant), 32'h1);
      wait_drain("t2b", 60);
      check_xf("t2b_x0", 0, 8'h04, 1'b1);
      check_xf("t2b_x3", 3, 8'h06, 1'b1);
      check_xf("t2b_x5", 5, 8'h60, 1'b0);

      // Test 3: backpressure mid-payload
      do_reset();
      for (int k = 0; k < 5; k++) push(1, 1'b1, t3d[k]);
      push(1, 1'b0, t3d[5]);
      drive_sources();
      tick();
      check_eq("t3_grant", 32'(grant), 32'h2);
      wait_xf("t3", 3, 20);
      rtr_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq($sformatf("t3_busy%0d", k), 32'(src_busy), 32'h7);
         check_eq($sformatf("t3_hold%0d", k), 32'(rtr_data), 32'hC3);
      end
      rtr_busy = 1'b0;
      wait_drain("t3", 40);
      check_eq("t3_nxf", 32'(xlog.size()), 32'd6);
      for (int k = 0; k < 6; k++) check_xf($sformatf("t3_x%0d", k), k, t3d[k], k != 5);
      check_cyc_gap("t3_stall", 2, 3, 4);
      check_eq("t3_npd", 32'(pd_log.size()), 32'd1);
      check_eq("t3_nle", 32'(le_log.size()), 32'd0);

      // Test 4: short packet
      do_reset();
      push(0, 1'b1, 8'h10); push(0, 1'b1, 8'hA1); push(0, 1'b1, 8'hA2); push(0, 1'b0, 8'h55);
      drive_sources();
      tick();
      wait_xf("t4", 4, 20);
      check_eq("t4_le_now", 32'(len_err), 32'd1);
      check_eq("t4_gap_grant", 32'(grant), 32'd0);
      check_eq("t4_gap_busy", 32'(src_busy), 32'h7);
      wait_drain("t4", 20);
      check_xf("t4_x3", 3, 8'h55, 1'b0);
      check_eq("t4_nle", 32'(le_log.size()), 32'd1);
      check_eq("t4_npd", 32'(pd_log.size()), 32'd0);

      // Test 5: over-length packet
      do_reset();
      push(2, 1'b1, 8'h0A); push(2, 1'b1, 8'hB1); push(2, 1'b1, 8'hB2); push(2, 1'b1, 8'hEE);
      drive_sources();
      tick();
      check_eq("t5_grant", 32'(grant), 32'h4);
      wait_xf("t5", 4, 20);
      check_eq("t5_le_now", 32'(len_err), 32'd1);
      check_eq("t5_pd_now", 32'(pkt_done), 32'd1);
      wait_drain("t5", 20);
      check_xf("t5_x3", 3, 8'hEE, 1'b0);
      check_eq("t5_nle", 32'(le_log.size()), 32'd1);
      check_eq("t5_npd", 32'(pd_log.size()), 32'd1);

      // Test 6: asynchronous reset mid-payload, then a fresh request
      do_reset();
      push(0, 1'b1, 8'h10); push(0, 1'b1, 8'hD1); push(0, 1'b1, 8'hD2);
      push(0, 1'b1, 8'hD3); push(0, 1'b1, 8'hD4); push(0, 1'b0, 8'h77);
      drive_sources();
      tick();
      wait_xf("t6", 2, 20);
      check_eq("t6_pre_rvld", 32'(rtr_pkt_valid), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check_eq("t6_async_grant", 32'(grant), 32'd0);
      check_eq("t6_async_busy", 32'(src_busy), 32'h7);
      check_eq("t6_async_rvld", 32'(rtr_pkt_valid), 32'd0);
      check_eq("t6_async_rdata", 32'(rtr_data), 32'd0);
      check_eq("t6_async_flags", 32'({pkt_done, len_err}), 32'd0);
      srcq[0].delete();
      drive_sources();
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      clear_logs();
      push(1, 1'b1, 8'h05); push(1, 1'b1, 8'h77); push(1, 1'b0, 8'h72);
      drive_sources();
      tick();
      check_eq("t6_grant", 32'(grant), 32'h2);
      wait_drain("t6", 20);
      check_eq("t6_nxf", 32'(xlog.size()), 32'd3);
      check_xf("t6_x2", 2, 8'h72, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
